// File: rtl/ifetch_unit_pkg.sv
// Shared constants, types and helpers for the instruction fetch front end.
package ifetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned IQ_DEPTH_DEFAULT = 4;

  // Same opcode the decoder uses for JAL.
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

  // J-type immediate, sign-extended, bit 0 always zero.
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_unit_inst_queue.sv
// Circular instruction queue of {inst, pc} entries with push, pop and clear.
module inst_queue
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    clear_in,
  input  logic                    push_in,
  input  logic [31:0]             push_inst_in,
  input  logic [31:0]             push_pc_in,
  input  logic                    pop_in,
  output logic [31:0]             head_inst_out,
  output logic [31:0]             head_pc_out,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic                    full_out,
  output logic                    empty_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointer, count and storage update; clear overrides push/pop.
  always_comb begin
    do_pop  = pop_in && (count_q != '0);
    do_push = push_in && ((count_q != CNT_W'(DEPTH)) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (clear_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = '{inst: push_inst_in, pc: push_pc_in};
        tail_d        = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head_inst_out = mem_q[head_q].inst;
  assign head_pc_out   = mem_q[head_q].pc;
  assign count_out     = count_q;
  assign full_out      = (count_q == CNT_W'(DEPTH));
  assign empty_out     = (count_q == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC, single-outstanding memory fetch, JAL predecode,
// instruction queue and one-per-cycle issue to the decoder.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_data_in,
  input  logic        issue_stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        inst_req_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int unsigned CNT_W = $clog2(IQ_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         inst_req_q, inst_req_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_out_q, pc_out_d;

  logic             iq_push;
  logic             iq_pop;
  logic             iq_clear;
  logic [31:0]      iq_head_inst;
  logic [31:0]      iq_head_pc;
  logic [CNT_W-1:0] iq_count;
  logic             iq_full;
  logic             iq_empty;
  logic [31:0]      pc_seq;

  inst_queue #(
    .DEPTH (IQ_DEPTH)
  ) u_inst_queue (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_in      (iq_clear),
    .push_in       (iq_push),
    .push_inst_in  (mem_data_in),
    .push_pc_in    (pc_q),
    .pop_in        (iq_pop),
    .head_inst_out (iq_head_inst),
    .head_pc_out   (iq_head_pc),
    .count_out     (iq_count),
    .full_out      (iq_full),
    .empty_out     (iq_empty)
  );

  // Predecode the returning word: JAL redirects, everything else falls through.
  always_comb begin
    pc_seq = pc_q + 32'd4;
    if (mem_data_in[6:0] == OPC_JAL) begin
      pc_seq = pc_q + imm_j(mem_data_in);
    end
  end

  // Fetch FSM, PC update, queue control and issue to the decoder.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    inst_req_d = 1'b0;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    iq_push    = 1'b0;
    iq_pop     = 1'b0;
    iq_clear   = 1'b0;

    if (rdy_in) begin
      if (flush_in) begin
        iq_clear = 1'b1;
        pc_d     = flush_pc_in;
        case (state_q)
          FETCH_WAIT: begin
            mem_req_d = 1'b0;
            state_d   = mem_ready_in ? FETCH_IDLE : FETCH_DROP;
          end
          // A response landing together with a flush in DROP is the one being
          // discarded; leaving DROP here avoids waiting for a second response.
          FETCH_DROP: state_d = mem_ready_in ? FETCH_IDLE : FETCH_DROP;
          default:    state_d = FETCH_IDLE;
        endcase
      end else begin
        if (!iq_empty && !issue_stall_in) begin
          iq_pop     = 1'b1;
          inst_req_d = 1'b1;
          inst_d     = iq_head_inst;
          pc_out_d   = iq_head_pc;
        end
        case (state_q)
          FETCH_IDLE: begin
            if (iq_count < CNT_W'(IQ_DEPTH)) begin
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
              state_d    = FETCH_WAIT;
            end
          end
          FETCH_WAIT: begin
            if (mem_ready_in) begin
              iq_push   = !iq_full || iq_pop;
              mem_req_d = 1'b0;
              pc_d      = pc_seq;
              state_d   = FETCH_IDLE;
            end
          end
          FETCH_DROP: begin
            if (mem_ready_in) begin
              state_d = FETCH_IDLE;
            end
          end
          default: state_d = FETCH_IDLE;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      inst_req_q <= 1'b0;
      inst_q     <= '0;
      pc_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      inst_req_q <= inst_req_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
    end
  end

  assign mem_req_out  = mem_req_q;
  assign mem_addr_out = mem_addr_q;
  assign inst_req_out = inst_req_q;
  assign inst_out     = inst_q;
  assign pc_out       = pc_out_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic against a
// transaction-level reference (accepted-word scoreboard and fetch-address rule).
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ready_in;
  logic [31:0] mem_data_in;
  logic        issue_stall_in;
  logic        flush_in;
  logic [31:0] flush_pc_in;
  logic        inst_req_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .IQ_DEPTH (4)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_ready_in   (mem_ready_in),
    .mem_data_in    (mem_data_in),
    .issue_stall_in (issue_stall_in),
    .flush_in       (flush_in),
    .flush_pc_in    (flush_pc_in),
    .inst_req_out   (inst_req_out),
    .inst_out       (inst_out),
    .pc_out         (pc_out)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ent_t        sb[$];
  ent_t        last_pop;
  logic [31:0] issued_pcs[$];
  int unsigned issue_cyc[$];
  logic [31:0] fetch_addrs[$];
  logic [31:0] exp_fetch;
  bit          doomed;
  bit          mem_busy;
  int unsigned mem_rem;
  logic [31:0] mem_cur_addr;
  int unsigned mem_lat;
  bit          rand_lat;
  bit          exp_iss;
  bit          exp_iss_valid;
  int unsigned prev_cnt;
  bit          prev_cnt_valid;
  int unsigned cyc;
  bit          jal_en;
  logic [31:0] jal_addr;
  logic [31:0] jal_word;
  int unsigned jal_pct;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next fetch address after an accepted word, from the ISA rule.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
    int signed off;
    if (w[6:0] != 7'h6F) return pc + 32'd4;
    off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
          - int'(w[31]) * 1048576;
    return pc + 32'(off);
  endfunction

  function automatic logic [31:0] gen_word(input logic [31:0] addr);
    logic [31:0] r;
    r = $urandom;
    if (jal_en && addr == jal_addr) return jal_word;
    if ($urandom_range(99) < jal_pct) return {r[31:7], 7'h6F};
    return {r[31:7], 7'h13};
  endfunction

  // One clock: check outputs of the last edge, run memory and model, drive inputs.
  task automatic tick(input bit st, input bit fl, input logic [31:0] fpc, input bit rd);
    ent_t        e;
    bit          deliver;
    logic [31:0] dat;
    if (exp_iss_valid) chk("inst_req", 64'(inst_req_out), 64'(exp_iss));
    if (inst_req_out === 1'b1) begin
      issued_pcs.push_back(pc_out);
      issue_cyc.push_back(cyc);
      if (sb.size() == 0) chk("issue_from_empty", 64'(inst_req_out), 64'(0));
      else begin
        e = sb.pop_front();
        last_pop = e;
        chk("issue_pc", 64'(pc_out), 64'(e.pc));
        chk("issue_inst", 64'(inst_out), 64'(e.inst));
      end
    end
    deliver = 1'b0;
    dat     = '0;
    if (!mem_busy && mem_req_out === 1'b1) begin
      chk("fetch_addr", 64'(mem_addr_out), 64'(exp_fetch));
      if (prev_cnt_valid) chk("fetch_with_room", 64'(mem_req_out), 64'(prev_cnt < 4));
      fetch_addrs.push_back(mem_addr_out);
      mem_busy     = 1'b1;
      mem_rem      = rand_lat ? $urandom_range(1, 5) : mem_lat;
      mem_cur_addr = mem_addr_out;
    end else if (mem_busy && rd) begin
      mem_rem--;
      if (mem_rem == 0) begin
        deliver  = 1'b1;
        mem_busy = 1'b0;
        dat      = gen_word(mem_cur_addr);
      end
    end
    prev_cnt       = sb.size();
    prev_cnt_valid = 1'b1;
    if (rd) begin
      exp_iss = !fl && !st && (sb.size() > 0);
      if (fl) begin
        sb.delete();
        exp_fetch = fpc;
        doomed    = mem_busy;
      end else if (deliver) begin
        if (doomed) doomed = 1'b0;
        else begin
          e.inst = dat;
          e.pc   = mem_cur_addr;
          sb.push_back(e);
          exp_fetch = next_pc(mem_cur_addr, dat);
        end
      end
    end else begin
      exp_iss = 1'b0;
    end
    exp_iss_valid  = 1'b1;
    issue_stall_in = st;
    flush_in       = fl;
    flush_pc_in    = fpc;
    rdy_in         = rd;
    mem_ready_in   = deliver;
    mem_data_in    = dat;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    #1;
    rst_n_in       = 1'b0;
    issue_stall_in = 1'b0;
    flush_in       = 1'b0;
    flush_pc_in    = '0;
    rdy_in         = 1'b1;
    mem_ready_in   = 1'b0;
    mem_data_in    = '0;
    #1;
    chk("rst_mem_req", 64'(mem_req_out), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr_out), 64'(0));
    chk("rst_inst_req", 64'(inst_req_out), 64'(0));
    chk("rst_inst", 64'(inst_out), 64'(0));
    chk("rst_pc_out", 64'(pc_out), 64'(0));
    sb.delete();
    issued_pcs.delete();
    issue_cyc.delete();
    fetch_addrs.delete();
    exp_fetch      = 32'h0;
    doomed         = 1'b0;
    mem_busy       = 1'b0;
    exp_iss_valid  = 1'b0;
    prev_cnt_valid = 1'b0;
    @(negedge clk);
    rst_n_in = 1'b1;
  endtask

  task automatic run_issues(input int unsigned n, input int unsigned budget, input bit st);
    int unsigned target;
    int unsigned k;
    target = issued_pcs.size() + n;
    k      = 0;
    while (issued_pcs.size() < target && k < budget) begin
      tick(st, 1'b0, 32'h0, 1'b1);
      k++;
    end
    if (issued_pcs.size() < target) chk("issue_timeout", 64'(issued_pcs.size()), 64'(target));
  endtask

  task automatic wait_req(input bit st);
    int unsigned k;
    k = 0;
    do begin
      tick(st, 1'b0, 32'h0, 1'b1);
      k++;
    end while (!mem_busy && k < 50);
    if (!mem_busy) chk("req_timeout", 64'(mem_req_out), 64'(1));
  endtask

  task automatic expect_pc(input string tag, input int unsigned idx, input logic [31:0] exp);
    if (idx < issued_pcs.size()) chk(tag, 64'(issued_pcs[idx]), 64'(exp));
    else chk(tag, 64'(issued_pcs.size()), 64'(idx + 1));
  endtask

  task automatic expect_fetch(input string tag, input int unsigned idx, input logic [31:0] exp);
    if (idx < fetch_addrs.size()) chk(tag, 64'(fetch_addrs[idx]), 64'(exp));
    else chk(tag, 64'(fetch_addrs.size()), 64'(idx + 1));
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic [31:0] r;
    rst_n_in = 1'b0; rdy_in = 1'b1; issue_stall_in = 1'b0; flush_in = 1'b0;
    flush_pc_in = '0; mem_ready_in = 1'b0; mem_data_in = '0;
    cyc = 0; mem_lat = 1; rand_lat = 1'b0; jal_en = 1'b0; jal_pct = 0;
    jal_addr = '0; jal_word = '0; doomed = 1'b0; mem_busy = 1'b0; mem_rem = 0;
    exp_iss = 1'b0; exp_iss_valid = 1'b0; prev_cnt = 0; prev_cnt_valid = 1'b0;
    exp_fetch = '0; mem_cur_addr = '0; last_pop = '{inst: '0, pc: '0};
    @(negedge clk);

    // Straight-line stream, 1-cycle memory.
    do_reset();
    run_issues(4, 60, 1'b0);
    expect_pc("stream_pc0", 0, 32'h0);
    expect_pc("stream_pc1", 1, 32'h4);
    expect_pc("stream_pc2", 2, 32'h8);
    expect_pc("stream_pc3", 3, 32'hC);
    expect_fetch("stream_addr2", 2, 32'h8);

    // JAL at 0x8 with offset +0x100.
    jal_en = 1'b1; jal_addr = 32'h8; jal_word = 32'h1000006F;
    do_reset();
    run_issues(5, 80, 1'b0);
    expect_pc("jal_pc2", 2, 32'h8);
    expect_pc("jal_pc3", 3, 32'h108);
    expect_pc("jal_pc4", 4, 32'h10C);
    expect_fetch("jal_addr3", 3, 32'h108);
    jal_en = 1'b0;

    // Long stall fills the queue, then a 4-deep burst drains it.
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_fetches", 64'(fetch_addrs.size()), 64'(4));
    chk("stall_mem_req", 64'(mem_req_out), 64'(0));
    chk("stall_no_issue", 64'(issued_pcs.size()), 64'(0));
    run_issues(4, 20, 1'b0);
    expect_pc("burst_pc0", 0, 32'h0);
    expect_pc("burst_pc3", 3, 32'hC);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < issue_cyc.size()) chk("burst_gap", 64'(issue_cyc[i+1] - issue_cyc[i]), 64'(1));
    end
    run_issues(1, 40, 1'b0);
    expect_pc("burst_resume", 4, 32'h10);

    // Flush while a slow fetch is outstanding and the queue holds data.
    mem_lat = 5;
    do_reset();
    k = 0;
    while (!(fetch_addrs.size() == 2 && mem_busy) && k < 60) begin
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      k++;
    end
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h200, 1'b1);
    run_issues(1, 100, 1'b0);
    expect_pc("flush_wait_pc", 0, 32'h200);
    expect_fetch("flush_wait_addr", 2, 32'h200);

    // Flush coinciding with mem_ready, then two flushes around DROP.
    mem_lat = 3;
    do_reset();
    k = 0;
    while (!(mem_busy && mem_rem == 1) && k < 40) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      k++;
    end
    tick(1'b0, 1'b1, 32'h300, 1'b1);
    mem_lat = 6;
    wait_req(1'b0);
    tick(1'b0, 1'b1, 32'h400, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h500, 1'b1);
    run_issues(1, 100, 1'b0);
    expect_pc("drop_pc", 0, 32'h500);
    expect_fetch("drop_addr1", 1, 32'h300);
    expect_fetch("drop_addr2", 2, 32'h500);

    // rdy_in low freezes state; then asynchronous reset mid-stream.
    mem_lat = 2;
    do_reset();
    run_issues(2, 60, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      chk("frz_pc_out", 64'(pc_out), 64'(last_pop.pc));
      chk("frz_inst", 64'(inst_out), 64'(last_pop.inst));
      chk("frz_mem_req", 64'(mem_req_out), 64'(mem_busy));
    end
    do_reset();
    run_issues(2, 60, 1'b0);
    expect_pc("rst_restart_pc0", 0, 32'h0);
    expect_pc("rst_restart_pc1", 1, 32'h4);

    // Randomized traffic: stalls, flushes, rdy gaps, random JALs and latencies.
    rand_lat = 1'b1;
    jal_pct  = 15;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit st, rd, fl;
      st = ($urandom_range(99) < 30);
      rd = ($urandom_range(99) < 90);
      fl = rd && ($urandom_range(99) < 3);
      r  = $urandom;
      tick(st, fl, {r[31:2], 2'b00}, rd);
    end
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Front-end stage directly upstream of the instruction decoder. Keeps the PC and fetches 32-bit words from the memory/icache controller.
- Buffers fetched words in a small instruction queue and hands one instruction per cycle to the decoder as an inst_req/inst pulse.
- Predecodes JAL to redirect fetch; all other control flow is predicted not-taken and corrected later through flush_in.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- IQ_DEPTH, 4, instruction queue entries; power of two, >= 2.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; low freezes all state
- mem_req_out  output  1  fetch request, held until mem_ready_in
- mem_addr_out  output  32  fetch address (word-aligned PC)
- mem_ready_in  input  1  one-cycle pulse, mem_data_in valid
- mem_data_in  input  32  fetched instruction word
- issue_stall_in  input  1  downstream (RS/ROB/LSB) cannot accept
- flush_in  input  1  mispredict/redirect pulse from commit
- flush_pc_in  input  32  redirect target
- inst_req_out  output  1  registered; inst_out/pc_out valid this cycle (drives decoder inst_req)
- inst_out  output  32  instruction to decoder
- pc_out  output  32  PC of inst_out

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset values: pc=RESET_PC; queue empty (head=tail=count=0); state=IDLE; mem_req_out=0; mem_addr_out=0; inst_req_out=0; inst_out=0; pc_out=0.
- rdy_in=0: every register holds and inst_req_out is forced 0 next edge. flush_in is ignored while rdy_in=0; commit does not pulse it then.
- FSM states: IDLE, WAIT, DROP.
- IDLE: if count<IQ_DEPTH and !flush_in, assert mem_req_out with mem_addr_out=pc and go to WAIT. The request is registered, one cycle after the decision.
- WAIT: hold mem_req_out/mem_addr_out. On mem_ready_in:
  - enqueue {mem_data_in, pc} at tail;
  - deassert mem_req_out and return to IDLE;
  - next pc = pc+immJ if mem_data_in[6:0]==7'b1101111 (immJ sign-extended, bit0=0), else pc+4. Arithmetic is 32-bit and wraps modulo 2^32.
- Only one fetch is outstanding, and a fetch starts only when count<IQ_DEPTH, so the queue never overflows.
- Dequeue: each cycle, if count>0 and !issue_stall_in, pop head into inst_out/pc_out and set inst_req_out=1; otherwise inst_req_out=0 and inst_out/pc_out hold.
- Dequeue latency is one cycle. An entry written at edge N can be presented at edge N+1 at the earliest; there is no bypass.
- Simultaneous enqueue and dequeue: count unchanged, head and tail both advance. Pointers wrap modulo IQ_DEPTH.
- Flush (flush_in=1, rdy_in=1) has highest priority:
  - queue emptied; inst_req_out=0 next cycle; pc=flush_pc_in.
  - IDLE stays IDLE; the new fetch is decided the next cycle.
  - WAIT without mem_ready_in goes to DROP with mem_req_out=0. The controller still completes the transfer and returns exactly one mem_ready_in, which is discarded.
  - WAIT with mem_ready_in the same cycle: data discarded, go to IDLE.
  - DROP: pc updated, stay in DROP.
- DROP: on mem_ready_in, discard the data and go to IDLE; no enqueue, pc unchanged.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight memory response after reset release arrives with state=IDLE and is ignored, because mem_ready_in is ignored in IDLE.
- Output constraints: inst_req_out never asserts in a cycle where issue_stall_in was sampled high. mem_addr_out[1:0] is always 2'b00 for aligned targets; flush_pc_in alignment is commit's responsibility.

Decomposition:
- Shared package/const include: RESET_PC default, the JAL opcode constant (same 7'b1101111 the decoder uses), FSM state encodings (IDLE/WAIT/DROP), and the IQ_DEPTH default.
- One natural sub-module: inst_queue, a circular FIFO of {inst[31:0], pc[31:0]} with push, pop, clear, count and full/empty.
- FSM, PC update and JAL predecode stay in ifetch_unit.

Test Plan:
- Reset then stream: memory returns ADDI words with 1-cycle latency, no stall -> mem_addr_out sequence 0x0, 0x4, 0x8…; inst_req_out pulses with pc_out 0x0, 0x4, 0x8 in order.
- JAL at 0x8 with offset +0x100 (word 0x1000006F) -> the fetch after 0x8 is at 0x108; pc_out sequence 0x0, 0x4, 0x8, 0x108.
- issue_stall_in held high for 20 cycles -> queue fills to IQ_DEPTH=4, mem_req_out stays 0 once full, inst_req_out=0 throughout. On release, 4 consecutive pulses pc 0x0..0xC, then fetching resumes at 0x10.
- flush_in with flush_pc_in=0x200 while in WAIT (memory latency 5) -> the late response is discarded and never issued, the queue is emptied, and the next mem_addr_out is 0x200. The first inst_req_out after the flush carries pc 0x200.
- flush_in in the same cycle as mem_ready_in -> that word is never issued and the next fetch is at flush_pc_in. A second flush during DROP -> the later target wins.
- rdy_in low for 3 cycles mid-stream, then rst_n_in pulsed low asynchronously between edges -> state frozen during rdy_in low. Outputs go to reset values immediately on reset, and fetch restarts at RESET_PC.
